// File: rtl/shift_seq_pkg.sv
// Shared definitions for the serial shift-chain sequencer.
//   state_e   : sequencer state encoding (IDLE, SHIFT, DONE)
//   bit_cnt_w : width of a counter that must hold 0..WIDTH
//   div_cnt_w : width of the bit-period divider, never less than one bit
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int bit_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int div_cnt_w(input int bit_div);
        int w;
        w = $clog2(bit_div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bit_strobe_gen.sv
// Bit-period divider for the shift sequencer.
// Counts 0..BIT_DIV-1 while enabled and raises strobe during the last count
// of each period. The counter is held at zero whenever en is low, so every
// transfer starts on a fresh period.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   en     : run the divider (sequencer is shifting)
//   strobe : high for the final cycle of each bit period
module bit_strobe_gen
    import shift_seq_pkg::*;
#(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic strobe
);

    localparam int DIV_W = div_cnt_w(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!en) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // With BIT_DIV=1 the last count is zero, so strobe follows en directly.
    assign strobe = en && (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial shift-chain sequencer.
// Accepts a parallel word on start, sends it LSB-first on ser_o with one
// ser_en strobe per bit period, and assembles the returning ser_i bits into
// dout. The received word is published on dout together with a one-cycle
// done pulse.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   start  : begin a transfer (only looked at in IDLE)
//   abort  : cancel a transfer (only looked at in SHIFT)
//   din    : word to send, captured when start is accepted
//   ser_i  : serial return bit from the chain
//   ser_o  : serial bit to the chain
//   ser_en : shift/sample strobe, one cycle per bit period
//   busy   : transfer in progress, including the done cycle
//   done   : one-cycle completion pulse
//   dout   : last completed received word
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; ser_o low
// SHIFT | sending/receiving bits, one per BIT_DIV cycles
// DONE  | single cycle: done high, dout holds the new word
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int BIT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_i,
    output logic             ser_o,
    output logic             ser_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int CNT_W = bit_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] tx_sh_q;
    logic [WIDTH-1:0] tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q;
    logic [WIDTH-1:0] rx_sh_d;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic             ser_o_q;
    logic             ser_o_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic             shift_en;
    logic             strobe;
    logic [WIDTH-1:0] tx_next;
    logic [WIDTH-1:0] rx_next;

    assign shift_en = (state_q == SHIFT);

    bit_strobe_gen #(
        .BIT_DIV (BIT_DIV)
    ) u_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (shift_en),
        .strobe (strobe)
    );

    // Whole-register shifts; the returning bit enters at the MSB so the
    // first bit received ends up in bit 0 after WIDTH strobes.
    assign tx_next = tx_sh_q >> 1;
    assign rx_next = (rx_sh_q >> 1) | {ser_i, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        dout_d    = dout_q;
        bit_cnt_d = bit_cnt_q;
        ser_o_d   = ser_o_q;

        case (state_q)
            IDLE: begin
                ser_o_d = 1'b0;
                if (start) begin
                    tx_sh_d   = din;
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                    ser_o_d   = din[0];
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                // abort wins over a strobe landing on the same edge
                if (abort) begin
                    ser_o_d = 1'b0;
                    state_d = IDLE;
                end else if (strobe) begin
                    tx_sh_d   = tx_next;
                    rx_sh_d   = rx_next;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        ser_o_d = 1'b0;
                        dout_d  = rx_next;
                        state_d = DONE;
                    end else begin
                        ser_o_d = tx_next[0];
                    end
                end
            end

            DONE: begin
                ser_o_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                ser_o_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of where the FSM is heading.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            dout_q    <= '0;
            bit_cnt_q <= '0;
            ser_o_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            dout_q    <= dout_d;
            bit_cnt_q <= bit_cnt_d;
            ser_o_q   <= ser_o_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ser_o  = ser_o_q;
    assign ser_en = strobe;
    assign busy   = busy_q;
    assign done   = done_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (BIT_DIV=1 and BIT_DIV=4, WIDTH=8)
// checked cycle by cycle against a timing model built from the bit-period
// arithmetic: strobe on every d-th cycle after the start edge, ser_o carrying
// word[(c-1)/d], done in cycle WIDTH*d+1, dout assembled from the ser_i bits
// present at each strobe.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             start_s  [2];
    logic             abort_s  [2];
    logic             ser_i_s  [2];
    logic [WIDTH-1:0] din_s    [2];
    logic             ser_o_s  [2];
    logic             ser_en_s [2];
    logic             busy_s   [2];
    logic             done_s   [2];
    logic [WIDTH-1:0] dout_s   [2];

    logic [WIDTH-1:0] exp_dout [2];

    int n_vec = 0;
    int n_err = 0;

    shift_seq_ctrl #(.WIDTH(WIDTH), .BIT_DIV(1)) u_dut_d1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_s[0]),
        .abort  (abort_s[0]),
        .din    (din_s[0]),
        .ser_i  (ser_i_s[0]),
        .ser_o  (ser_o_s[0]),
        .ser_en (ser_en_s[0]),
        .busy   (busy_s[0]),
        .done   (done_s[0]),
        .dout   (dout_s[0])
    );

    shift_seq_ctrl #(.WIDTH(WIDTH), .BIT_DIV(4)) u_dut_d4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_s[1]),
        .abort  (abort_s[1]),
        .din    (din_s[1]),
        .ser_i  (ser_i_s[1]),
        .ser_o  (ser_o_s[1]),
        .ser_en (ser_en_s[1]),
        .busy   (busy_s[1]),
        .done   (done_s[1]),
        .dout   (dout_s[1])
    );

    // One transfer on instance sel, starting at a negedge with the DUT idle.
    //   ser_mode : 0 = ser_i follows ser_o (aligned loop), 1 = tied high, 2 = random
    //   cut_kind : 0 = none, 1 = abort, 2 = reset, applied once cut_after bits are done
    //   hold     : leave start high afterwards (back-to-back)
    //   poke     : re-pulse start with din=8'h11 while shifting
    task automatic run_xfer(input int sel, input logic [WIDTH-1:0] word, input int ser_mode,
                            input int cut_kind, input int cut_after, input bit hold,
                            input bit poke);
        int d;
        int n_cyc;
        int k;
        logic [WIDTH-1:0] rx_exp;
        logic [3:0] obs;
        logic [3:0] exp_v;
        d      = (sel == 0) ? 1 : 4;
        n_cyc  = WIDTH * d;
        rx_exp = '0;
        k      = 0;
        din_s[sel]   = word;
        start_s[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start_s[sel] = 1'b0;
        for (int c = 1; c <= n_cyc + 1; c++) begin
            obs   = {ser_en_s[sel], ser_o_s[sel], busy_s[sel], done_s[sel]};
            exp_v = {(c <= n_cyc) && (c % d == 0),
                     (c <= n_cyc) ? word[(c - 1) / d] : 1'b0,
                     1'b1,
                     c == n_cyc + 1};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL xfer sel=%0d word=%h cyc=%0d {ser_en,ser_o,busy,done} got %b want %b",
                         sel, word, c, obs, exp_v);
            end
            if (c == n_cyc + 1) begin
                exp_dout[sel] = (ser_mode == 0) ? word : rx_exp;
                n_vec++;
                if (dout_s[sel] !== exp_dout[sel]) begin
                    n_err++;
                    $display("FAIL dout sel=%0d word=%h got %h want %h",
                             sel, word, dout_s[sel], exp_dout[sel]);
                end
            end
            if (cut_kind != 0 && c <= n_cyc && (c - 1) / d == cut_after) begin
                if (cut_kind == 1) begin
                    abort_s[sel] = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    abort_s[sel] = 1'b0;
                    obs = {ser_en_s[sel], ser_o_s[sel], busy_s[sel], done_s[sel]};
                    n_vec++;
                    if (obs !== 4'b0000) begin
                        n_err++;
                        $display("FAIL abort_idle sel=%0d got %b want 0000", sel, obs);
                    end
                end else begin
                    rst_n = 1'b0;
                    #1;
                    exp_dout[0] = '0;
                    exp_dout[1] = '0;
                    obs = {ser_en_s[sel], ser_o_s[sel], busy_s[sel], done_s[sel]};
                    n_vec++;
                    if (obs !== 4'b0000) begin
                        n_err++;
                        $display("FAIL reset_async sel=%0d got %b want 0000", sel, obs);
                    end
                    n_vec++;
                    if (dout_s[0] !== '0 || dout_s[1] !== '0) begin
                        n_err++;
                        $display("FAIL reset_dout got %h/%h want 00/00", dout_s[0], dout_s[1]);
                    end
                    @(posedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    @(negedge clk);
                    n_vec++;
                    if (busy_s[sel] !== 1'b0 || done_s[sel] !== 1'b0 ||
                        dout_s[sel] !== exp_dout[sel]) begin
                        n_err++;
                        $display("FAIL post_cut sel=%0d busy=%b done=%b dout=%h want 0 0 %h",
                                 sel, busy_s[sel], done_s[sel], dout_s[sel], exp_dout[sel]);
                    end
                end
                return;
            end
            case (ser_mode)
                0:       ser_i_s[sel] = ser_o_s[sel];
                1:       ser_i_s[sel] = 1'b1;
                default: ser_i_s[sel] = 1'($urandom_range(0, 1));
            endcase
            if (c <= n_cyc && c % d == 0) begin
                rx_exp[k] = ser_i_s[sel];
                k++;
            end
            if (poke && c == 2) begin
                start_s[sel] = 1'b1;
                din_s[sel]   = 8'h11;
            end else if (poke && c == 3) begin
                start_s[sel] = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        obs = {ser_en_s[sel], ser_o_s[sel], busy_s[sel], done_s[sel]};
        n_vec++;
        if (obs !== 4'b0000 || dout_s[sel] !== exp_dout[sel]) begin
            n_err++;
            $display("FAIL idle_gap sel=%0d got %b dout=%h want 0000 dout=%h",
                     sel, obs, dout_s[sel], exp_dout[sel]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start_s[s] = 1'b0;
            abort_s[s] = 1'b0;
            ser_i_s[s] = 1'b0;
            din_s[s]   = '0;
            exp_dout[s] = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_vec++;
            if ({ser_en_s[s], ser_o_s[s], busy_s[s], done_s[s]} !== 4'b0000 || dout_s[s] !== '0) begin
                n_err++;
                $display("FAIL reset sel=%0d outs=%b dout=%h want 0000 00", s,
                         {ser_en_s[s], ser_o_s[s], busy_s[s], done_s[s]}, dout_s[s]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy_s[0] !== 1'b0 || busy_s[1] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release busy got %b%b want 00", busy_s[0], busy_s[1]);
        end
    endtask

    task automatic test_loopback();
        run_xfer(0, 8'hA5, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_div4_tied();
        run_xfer(1, 8'h3C, 1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        run_xfer(0, 8'hF0, 2, 1, 3, 1'b0, 1'b0);
        run_xfer(0, 8'h96, 0, 0, 0, 1'b0, 1'b0);
        run_xfer(1, 8'h5A, 2, 1, 5, 1'b0, 1'b0);
        run_xfer(1, 8'hC7, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        run_xfer(0, 8'h5A, 0, 0, 0, 1'b0, 1'b1);
        run_xfer(1, 8'h5A, 0, 0, 0, 1'b0, 1'b1);
        abort_s[0] = 1'b1;
        abort_s[1] = 1'b1;
        repeat (2) @(negedge clk);
        abort_s[0] = 1'b0;
        abort_s[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            n_vec++;
            if (busy_s[s] !== 1'b0 || dout_s[s] !== exp_dout[s]) begin
                n_err++;
                $display("FAIL idle_abort sel=%0d busy=%b dout=%h want 0 %h",
                         s, busy_s[s], dout_s[s], exp_dout[s]);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_xfer(0, 8'hC3, 0, 2, 4, 1'b0, 1'b0);
        run_xfer(0, 8'h3A, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_xfer(0, 8'h81, 0, 0, 0, 1'b1, 1'b0);
        run_xfer(0, 8'h81, 0, 0, 0, 1'b1, 1'b0);
        run_xfer(0, 8'h81, 0, 0, 0, 1'b0, 1'b0);
        run_xfer(1, 8'h81, 0, 0, 0, 1'b1, 1'b0);
        run_xfer(1, 8'h81, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int sel;
        int cut;
        logic [WIDTH-1:0] w;
        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(0, 1));
            w   = WIDTH'($urandom);
            cut = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_xfer(sel, w, 2, cut, int'($urandom_range(0, WIDTH - 1)), 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_div4_tied();
        test_abort();
        test_ignored_inputs();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for the team's serial shift chains. It accepts a parallel word on a start pulse and serializes it LSB-first. It generates a one-cycle shift-enable strobe per bit for the downstream shift register, and captures the returning serial bit into a parallel result. It sits between a parallel producer/consumer and a serial-in serial-out delay chain, and owns all bit timing and transfer framing.

Parameters:
WIDTH, 8, bits per transfer (legal range ≥2).
BIT_DIV, 1, clk cycles per bit period (legal range ≥1).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin transfer; sampled only in IDLE.
abort  input  1  cancel transfer; sampled only in SHIFT.
din  input  WIDTH  parallel word to send; latched on the accepted start.
ser_i  input  1  serial return bit from the chain.
ser_o  output  1  serial bit to the chain.
ser_en  output  1  one-cycle shift/sample strobe, once per bit period.
busy  output  1  transfer in progress.
done  output  1  one-cycle pulse on transfer completion.
dout  output  WIDTH  last completed received word.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - ser_o=0, ser_en=0, busy=0, done=0, dout=0.
  - Internal tx/rx shift registers and counters cleared.
- States: IDLE, SHIFT, DONE. All outputs registered.
- IDLE:
  - start=1 at an edge → latch din into tx_sh, clear rx_sh, bit_cnt=0, div_cnt=0, go to SHIFT.
  - ser_o = din[0] from that edge.
- SHIFT:
  - busy=1.
  - div_cnt counts 0..BIT_DIV-1 and wraps.
  - ser_en=1 for exactly one cycle when div_cnt==BIT_DIV-1.
  - The edge ending that cycle is the strobe edge. On it:
    - rx_sh <= {ser_i, rx_sh[WIDTH-1:1]}.
    - tx_sh shifts right 1.
    - ser_o takes the next bit.
    - bit_cnt++.
  - On the WIDTH-th strobe edge → DONE, and ser_o=0.
  - abort=1 → IDLE at the next edge. ser_o=0, no done pulse, dout unchanged. abort takes priority over a coincident strobe.
- DONE (one cycle): done=1, busy=1, dout=rx_sh (final value), then IDLE unconditionally.
- Timing, start accepted at edge E0:
  - first ser_en in the cycle after edge E0+BIT_DIV-1.
  - done high in the cycle after edge E0+WIDTH*BIT_DIV.
  - busy high from E0 through the done cycle.
- Ignored inputs:
  - start in SHIFT or DONE is ignored, not queued.
  - abort in IDLE or DONE is ignored.
  - Back-to-back: start held high re-accepts in IDLE, so the minimum gap between transfers is one IDLE cycle.
- BIT_DIV=1: ser_en is high every SHIFT cycle.
- Widths: bit_cnt is $clog2(WIDTH+1) bits; div_cnt is max(1,$clog2(BIT_DIV)) bits. No overflow is possible within legal parameters.
- Reset mid-transfer: immediate return to reset values, no done pulse.

Decomposition:
- Package shift_seq_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - the localparam width-function helpers for the counter widths.
- Sub-module bit_strobe_gen(clk, rst_n, en, strobe), parameter BIT_DIV: the div_cnt counter.
  - Held cleared when en=0.
  - Instantiated with en = (state==SHIFT).
- The rest is flat.

Test Plan:
- WIDTH=8, BIT_DIV=1, din=8'hA5, start pulse, ser_i looped to ser_o through a 1-stage register ahead of sampling → ser_o across strobes = 1,0,1,0,0,1,0,1. Expect 8 ser_en cycles, done exactly 9 cycles after the start edge, dout=8'hA5.
- BIT_DIV=4, din=8'h3C, ser_i tied 1 → ser_en period 4 (first after edge E0+3), done at edge-relative 33, dout=8'hFF, busy high for 33 cycles.
- Abort after 3 strobes (BIT_DIV=1, din=8'hF0) → IDLE next edge, no done, dout keeps its previous value. A new start then completes normally.
- start reasserted with din=8'h11 while in SHIFT → ignored. Current transfer of 8'h5A completes with the original bit sequence; one done only.
- rst_n low mid-SHIFT (after 4 strobes) → all outputs 0 asynchronously, including dout; after release stays IDLE until start.
- start held high continuously with din=8'h81 → transfers repeat with exactly one IDLE cycle between done and the next busy; dout=8'h81 each time with ser_i looped.
